// File: rtl/fpu_pkg.sv
// Shared types and opcodes for the FP op scheduler.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef logic [31:0] fp32_t;

  // One latched request: opcode, operands and the owning requester.
  typedef struct packed {
    logic [2:0] op;
    fp32_t      a;
    fp32_t      b;
    logic       id;
  } op_req_t;

  // Opcodes 5..7 have no ALU function behind them.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_CMP;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; pointer names the requester with priority.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr_q;

  // Grant the pointer requester if it asks, otherwise the other one.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[ptr_q])       gnt[ptr_q]  = 1'b1;
      else if (req[!ptr_q]) gnt[!ptr_q] = 1'b1;
    end
  end

  // On every accepted grant, priority passes to the requester that lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_q <= 1'b0;
    else if (accept) ptr_q <= !gnt[1];
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Shares one FP ALU between two requesters: arbitrate, issue, wait, respond.
module fpu_op_scheduler
  import fpu_pkg::*;
#(
  parameter int LAT_ADD = 4,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 8,
  parameter int LAT_CMP = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][2:0]  req_op,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  output logic [2:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  input  logic             alu_eq,
  input  logic             alu_gt,
  input  logic             alu_lt,
  output logic             busy
);

  state_t           state_q, state_d;
  op_req_t          cur_q;
  logic [CNT_W-1:0] cnt_q, lat_m1;
  logic [1:0]       gnt;
  logic             hs, win_id;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .en     (state_q == IDLE),
    .accept (hs),
    .gnt    (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);
  assign win_id    = gnt[1];

  // ALU inputs come straight from the latch, so they stay put until the next grant.
  assign alu_op    = cur_q.op;
  assign alu_a     = cur_q.a;
  assign alu_b     = cur_q.b;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP) ? (cur_q.id ? 2'b10 : 2'b01) : 2'b00;

  // Wait length minus one, since the capture happens on the count==0 cycle.
  always_comb begin
    lat_m1 = '0;
    case (cur_q.op)
      OP_ADD, OP_SUB: lat_m1 = CNT_W'(LAT_ADD - 1);
      OP_MUL:         lat_m1 = CNT_W'(LAT_MUL - 1);
      OP_DIV:         lat_m1 = CNT_W'(LAT_DIV - 1);
      OP_CMP:         lat_m1 = CNT_W'(LAT_CMP - 1);
      default:        lat_m1 = '0;
    endcase
  end

  // Next-state logic for the single-op-in-flight sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (hs) state_d = ISSUE;
      ISSUE: state_d = op_legal(cur_q.op) ? WAIT : RESP;
      WAIT:  if (cnt_q == '0) state_d = RESP;
      RESP:  if (rsp_ready[cur_q.id]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request latch, latency counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q     <= '0;
      cnt_q     <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (hs) cur_q <= '{op: req_op[win_id], a: req_a[win_id],
                                 b: req_b[win_id], id: win_id};
        ISSUE: begin
          cnt_q <= lat_m1;
          if (!op_legal(cur_q.op)) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            // Compares report only flags; arithmetic ops report only data.
            rsp_data  <= (cur_q.op == OP_CMP) ? '0 : alu_out;
            rsp_flags <= (cur_q.op == OP_CMP) ? {alu_lt, alu_gt, alu_eq} : 3'b000;
            rsp_err   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler with a table-driven ALU stub.
module tb_fpu_op_scheduler;

  localparam logic [31:0] F_ONE   = 32'h3F800000;
  localparam logic [31:0] F_M_ONE = 32'hBF800000;
  localparam logic [31:0] F_TWO   = 32'h40000000;
  localparam logic [31:0] F_THREE = 32'h40400000;
  localparam logic [31:0] F_SIX   = 32'h40C00000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][2:0]  req_op;
  logic [1:0][31:0] req_a, req_b;
  logic [31:0]      rsp_data, alu_a, alu_b, alu_out;
  logic [2:0]       rsp_flags, alu_op;
  logic             rsp_err, alu_eq, alu_gt, alu_lt, busy;

  int total = 0;
  int bad   = 0;
  int n;
  logic [31:0] held;

  always #5 clk = ~clk;

  fpu_op_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt), .busy(busy)
  );

  // Sign-magnitude compare of two non-NaN floats: {lt,gt,eq}.
  function automatic logic [2:0] fcmp(input logic [31:0] a, input logic [31:0] b);
    logic mag_gt;
    if (a == b) return 3'b001;
    if (a[31] != b[31]) return a[31] ? 3'b100 : 3'b010;
    mag_gt = a[30:0] > b[30:0];
    if (!a[31]) return mag_gt ? 3'b010 : 3'b100;
    return mag_gt ? 3'b100 : 3'b010;
  endfunction

  // ALU stub: hand-computed results for the operand pairs the bench uses.
  // Flags are always driven so that masking on non-compare ops is visible.
  always_comb begin
    alu_out = 32'hDEADBEEF;
    case (alu_op)
      3'd0: if (alu_a == F_ONE   && alu_b == F_TWO)   alu_out = F_THREE;
      3'd1: if (alu_a == F_THREE && alu_b == F_ONE)   alu_out = F_TWO;
      3'd2: if (alu_a == F_TWO   && alu_b == F_THREE) alu_out = F_SIX;
      3'd3: if (alu_a == F_SIX   && alu_b == F_TWO)   alu_out = F_THREE;
      3'd4: alu_out = 32'h12345678;
      default: ;
    endcase
    {alu_lt, alu_gt, alu_eq} = fcmp(alu_a, alu_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Raise valid, wait for grant, take the handshake edge, drop valid.
  task automatic send(input int id, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    int w;
    req_op[id] = op; req_a[id] = a; req_b[id] = b; req_valid[id] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[id] && w < 50) begin tick(); w++; end
    if (!req_ready[id]) check("grant_timeout", 32'd0, 32'd1);
    tick();
    req_valid[id] = 1'b0;
  endtask

  // Count edges from the handshake edge until rsp_valid[id] shows.
  task automatic wait_rsp(input int id, output int cyc);
    cyc = 0;
    while (!rsp_valid[id] && cyc < 40) begin tick(); cyc++; end
    if (!rsp_valid[id]) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0;
    #2;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_alu", {alu_op, alu_a[28:0]}, 32'd0);
    tick(); rst_n = 1'b1; tick();

    // 1: single add, latency LAT_ADD+1 from the handshake edge
    send(0, 3'd0, F_ONE, F_TWO);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_alu_a", alu_a, F_ONE);
    wait_rsp(0, n);
    check("t1_lat", n, 32'd5);
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_data", rsp_data, F_THREE);
    check("t1_flags", 32'(rsp_flags), 32'd0);
    rsp_ready = 2'b01; tick();
    check("t1_done", 32'(rsp_valid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: both valid together, pointer at 0 after reset
    do_reset();
    rsp_ready = 2'b11;
    req_op[0] = 3'd2; req_a[0] = F_TWO; req_b[0] = F_THREE;
    req_op[1] = 3'd3; req_a[1] = F_SIX; req_b[1] = F_TWO;
    req_valid = 2'b11; #1;
    check("t2_gnt0", 32'(req_ready), 32'd1);
    tick(); req_valid[0] = 1'b0; #1;
    check("t2_noready", 32'(req_ready), 32'd0);
    wait_rsp(0, n);
    check("t2_lat0", n, 32'd5);
    check("t2_data0", rsp_data, F_SIX);
    tick();
    check("t2_gnt1", 32'(req_ready), 32'd2);
    tick(); req_valid[1] = 1'b0;
    wait_rsp(1, n);
    check("t2_lat1", n, 32'd9);
    check("t2_valid1", 32'(rsp_valid), 32'd2);
    check("t2_data1", rsp_data, F_THREE);
    tick();

    // 3: compares
    send(0, 3'd4, F_ONE, F_ONE);
    wait_rsp(0, n);
    check("t3_lat", n, 32'd3);
    check("t3_eq_flags", 32'(rsp_flags), 32'd1);
    check("t3_eq_data", rsp_data, 32'd0);
    tick();
    send(0, 3'd4, F_M_ONE, F_ONE);
    wait_rsp(0, n);
    check("t3_lt_flags", 32'(rsp_flags), 32'd4);
    check("t3_lt_data", rsp_data, 32'd0);
    tick();

    // 4: illegal opcode skips the ALU wait
    send(1, 3'd6, F_SIX, F_TWO);
    wait_rsp(1, n);
    check("t4_lat", n, 32'd1);
    check("t4_err", 32'(rsp_err), 32'd1);
    check("t4_data", rsp_data, 32'd0);
    check("t4_flags", 32'(rsp_flags), 32'd0);
    tick();

    // 5: response held back; other requester and non-owner ready ignored
    rsp_ready = 2'b00;
    send(0, 3'd0, F_ONE, F_TWO);
    wait_rsp(0, n);
    held = rsp_data;
    check("t5_data", held, F_THREE);
    req_op[1] = 3'd1; req_a[1] = F_THREE; req_b[1] = F_ONE; req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check("t5_hold_data", rsp_data, held);
      check("t5_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready[0] = 1'b1; tick();
    check("t5_taken", 32'(rsp_valid), 32'd0);
    check("t5_next_gnt", 32'(req_ready), 32'd2);
    tick(); req_valid[1] = 1'b0;
    wait_rsp(1, n);
    check("t5_sub", rsp_data, F_TWO);
    check("t5_err", 32'(rsp_err), 32'd0);
    tick();

    // 6: reset during a divide's wait
    rsp_ready = 2'b11;
    send(0, 3'd3, F_SIX, F_TWO);
    tick(); tick(); tick(); tick();
    check("t6_inflight", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    check("t6_rst_out", {27'd0, rsp_valid, req_ready, busy}, 32'd0);
    check("t6_rst_alu", alu_a | alu_b | 32'(alu_op), 32'd0);
    tick(); tick();
    check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    req_valid = 2'b11; #1;
    check("t6_ptr0", 32'(req_ready), 32'd1);
    req_valid = 2'b00; #1;
    send(1, 3'd1, F_THREE, F_ONE);
    wait_rsp(1, n);
    check("t6_lat", n, 32'd5);
    check("t6_data", rsp_data, F_TWO);
    check("t6_flags", 32'(rsp_flags), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
